// File: rtl/stream_bit_reorder.sv
// AXI-Stream per-lane bit reorder with a 1-cycle output register plus skid buffer.
// The reorder mode is latched on the first beat of each packet and held until TLAST.
module stream_bit_reorder_lane #(
  parameter int DATA_WIDTH  = 32,
  parameter int GROUP_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic [1:0]            mode_i,
  output logic [DATA_WIDTH-1:0] dout_o
);
  localparam int G = DATA_WIDTH / GROUP_WIDTH;

  logic [DATA_WIDTH-1:0] bit_rev, grp_rev, in_grp_rev;

  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_bit
    assign bit_rev[j] = din_i[DATA_WIDTH-1-j];
  end

  for (genvar g = 0; g < G; g++) begin : g_grp
    for (genvar b = 0; b < GROUP_WIDTH; b++) begin : g_b
      assign grp_rev[g*GROUP_WIDTH+b]    = din_i[(G-1-g)*GROUP_WIDTH+b];
      assign in_grp_rev[g*GROUP_WIDTH+b] = din_i[g*GROUP_WIDTH+GROUP_WIDTH-1-b];
    end
  end

  always_comb begin
    dout_o = din_i;
    case (mode_i)
      2'b01:   dout_o = bit_rev;
      2'b10:   dout_o = grp_rev;
      2'b11:   dout_o = in_grp_rev;
      default: dout_o = din_i;
    endcase
  end
endmodule

module stream_bit_reorder #(
  parameter int DATA_WIDTH  = 32,
  parameter int N_STREAMS   = 1,
  parameter int GROUP_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [1:0]                      MODE,
  input  logic [N_STREAMS*DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  input  logic                            S_AXIS_TLAST,
  output logic [N_STREAMS*DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TLAST,
  output logic [1:0]                      ACTIVE_MODE,
  output logic                            PKT_ACTIVE
);
  if (DATA_WIDTH % GROUP_WIDTH != 0) begin : g_bad_group
    $error("DATA_WIDTH must be a multiple of GROUP_WIDTH");
  end

  typedef enum logic {IDLE, IN_PKT} state_t;
  typedef struct packed {
    logic                            last;
    logic [N_STREAMS*DATA_WIDTH-1:0] data;
  } beat_t;

  state_t state_q, state_d;
  logic [1:0] active_mode_q, active_mode_d;
  beat_t out_q, out_d, skid_q, skid_d, new_beat;
  logic out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, ready_q, ready_d;
  logic s_fire, out_free;
  logic [1:0] eff_mode;

  logic [N_STREAMS-1:0][DATA_WIDTH-1:0] lane_in, lane_out;

  assign lane_in  = S_AXIS_TDATA;
  // First beat of a packet uses the live MODE; later beats use the latched one.
  assign eff_mode = (state_q == IDLE) ? MODE : active_mode_q;

  for (genvar i = 0; i < N_STREAMS; i++) begin : g_lane
    stream_bit_reorder_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .GROUP_WIDTH(GROUP_WIDTH)
    ) u_lane (
      .din_i (lane_in[i]),
      .mode_i(eff_mode),
      .dout_o(lane_out[i])
    );
  end

  assign new_beat = '{last: S_AXIS_TLAST, data: lane_out};
  assign s_fire   = S_AXIS_TVALID & ready_q;
  assign out_free = ~out_vld_q | M_AXIS_TREADY;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (out_free) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = s_fire;
        if (s_fire) out_d = new_beat;
      end
    end else if (s_fire) begin
      skid_d     = new_beat;
      skid_vld_d = 1'b1;
    end
    // Registered ready: equals ~skid_vld_q out of reset, never depends on M ready.
    ready_d = ~skid_vld_d;
  end

  always_comb begin
    state_d       = state_q;
    active_mode_d = active_mode_q;
    if (s_fire) begin
      case (state_q)
        IDLE: begin
          active_mode_d = MODE;
          state_d       = S_AXIS_TLAST ? IDLE : IN_PKT;
        end
        IN_PKT: if (S_AXIS_TLAST) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      active_mode_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      active_mode_q <= active_mode_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      ready_q    <= ready_d;
    end
  end

  assign S_AXIS_TREADY = ready_q;
  assign M_AXIS_TVALID = out_vld_q;
  assign M_AXIS_TDATA  = out_q.data;
  assign M_AXIS_TLAST  = out_q.last;
  assign ACTIVE_MODE   = active_mode_q;
  assign PKT_ACTIVE    = (state_q == IN_PKT);
endmodule

// File: tb/tb_stream_bit_reorder.sv
// Scoreboard bench for stream_bit_reorder with two 32-bit lanes.
module tb_stream_bit_reorder;
  localparam int DW = 32;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic [1:0] MODE = 2'b00;
  logic [NS*DW-1:0] S_AXIS_TDATA = '0;
  logic S_AXIS_TVALID = 1'b0, S_AXIS_TLAST = 1'b0, M_AXIS_TREADY = 1'b0;
  logic S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, PKT_ACTIVE;
  logic [NS*DW-1:0] M_AXIS_TDATA;
  logic [1:0] ACTIVE_MODE;

  int checks = 0, errors = 0;
  logic [NS*DW:0] exp_q[$];
  logic rnd_rdy = 1'b0;

  always #5 clk = ~clk;

  stream_bit_reorder #(.DATA_WIDTH(DW), .N_STREAMS(NS), .GROUP_WIDTH(8)) dut (
    .clk(clk), .aresetn(aresetn), .MODE(MODE),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
    .ACTIVE_MODE(ACTIVE_MODE), .PKT_ACTIVE(PKT_ACTIVE)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next posedge if valid&ready hold now.
  initial forever begin
    @(negedge clk);
    if (aresetn && M_AXIS_TVALID && M_AXIS_TREADY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {M_AXIS_TLAST, M_AXIS_TDATA[62:0]}, 64'h0);
        if (M_AXIS_TDATA[62:0] == 63'h0 && !M_AXIS_TLAST) chk("unexpected_beat_zero", 64'h1, 64'h0);
      end else begin
        logic [NS*DW:0] e;
        e = exp_q.pop_front();
        chk("out_data", M_AXIS_TDATA, e[NS*DW-1:0]);
        chk("out_last", {63'h0, M_AXIS_TLAST}, {63'h0, e[NS*DW]});
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_rdy) M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [63:0] d, input logic l, input logic [1:0] m,
                      input logic [63:0] exp, output int edges);
    logic acc;
    S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = d; S_AXIS_TLAST = l; MODE = m;
    exp_q.push_back({l, exp});
    edges = 0; acc = 1'b0;
    while (!acc && edges < 1000) begin
      @(negedge clk); acc = S_AXIS_TREADY;
      @(posedge clk); #1; edges++;
    end
    S_AXIS_TVALID = 1'b0;
    if (!acc) chk("send_timeout", 64'h0, 64'h1);
  endtask

  task automatic drain();
    int n = 0;
    M_AXIS_TREADY = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] xf(input logic [31:0] d, input logic [1:0] m);
    logic [31:0] r;
    for (int i = 0; i < 32; i++)
      case (m)
        2'b00: r[i] = d[i];
        2'b01: r[i] = d[31-i];
        2'b10: r[i] = d[(3 - i/8)*8 + i%8];
        default: r[i] = d[(i/8)*8 + 7 - i%8];
      endcase
    return r;
  endfunction

  initial begin
    int e, tot;
    logic [31:0] a, b;
    logic [1:0] m, lm, eff;
    logic l, inp;

    #12;
    chk("rst_tready", S_AXIS_TREADY, 0);
    chk("rst_tvalid", M_AXIS_TVALID, 0);
    chk("rst_tlast", M_AXIS_TLAST, 0);
    chk("rst_tdata", M_AXIS_TDATA, 0);
    chk("rst_active_mode", ACTIVE_MODE, 0);
    chk("rst_pkt_active", PKT_ACTIVE, 0);
    @(posedge clk); #1; aresetn = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_tready", S_AXIS_TREADY, 1);
    M_AXIS_TREADY = 1'b1;

    // single-beat packets, all four modes
    send({2{32'h12345678}}, 1, 2'b00, {2{32'h12345678}}, e); chk("am00", ACTIVE_MODE, 0);
    send({2{32'h12345678}}, 1, 2'b01, {2{32'h1E6A2C48}}, e); chk("am01", ACTIVE_MODE, 1);
    send({2{32'h12345678}}, 1, 2'b10, {2{32'h78563412}}, e); chk("am10", ACTIVE_MODE, 2);
    send({2{32'h12345678}}, 1, 2'b11, {2{32'h482C6A1E}}, e); chk("am11", ACTIVE_MODE, 3);
    chk("single_pkt_idle", PKT_ACTIVE, 0);
    // lanes independent
    send({32'h00000001, 32'h80000000}, 1, 2'b01, {32'h80000000, 32'h00000001}, e);

    // mid-packet MODE change only applies to next packet
    send({2{32'h12345678}}, 0, 2'b01, {2{32'h1E6A2C48}}, e);
    chk("pkt_active_b1", PKT_ACTIVE, 1); chk("latched_mode", ACTIVE_MODE, 1);
    send({2{32'h00000001}}, 0, 2'b10, {2{32'h80000000}}, e);
    send({2{32'h0000000F}}, 0, 2'b10, {2{32'hF0000000}}, e);
    chk("pkt_active_b3", PKT_ACTIVE, 1);
    send({2{32'hFF000000}}, 1, 2'b10, {2{32'h000000FF}}, e);
    chk("pkt_active_b4", PKT_ACTIVE, 0);
    send({2{32'h12345678}}, 0, 2'b10, {2{32'h78563412}}, e);
    send({2{32'h000000FF}}, 1, 2'b00, {2{32'hFF000000}}, e);
    drain();

    // backpressure: two beats buffered, ready drops, output held stable
    M_AXIS_TREADY = 1'b0;
    send({2{32'h00000001}}, 0, 2'b00, {2{32'h00000001}}, e);
    send({2{32'h00000002}}, 0, 2'b00, {2{32'h00000002}}, e);
    chk("bp_tready_low", S_AXIS_TREADY, 0);
    S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = {2{32'h00000003}};
    @(posedge clk); #1;
    chk("bp_tready_low2", S_AXIS_TREADY, 0);
    chk("bp_hold_data", M_AXIS_TDATA, {2{32'h00000001}});
    chk("bp_hold_valid", M_AXIS_TVALID, 1);
    M_AXIS_TREADY = 1'b1;
    @(posedge clk); #1;
    tot = 0;
    for (int i = 3; i < 7; i++) begin
      send({2{i[31:0]}}, (i == 6), 2'b00, {2{i[31:0]}}, e); tot += e;
    end
    chk("throughput_4beats", tot, 4);
    drain();

    // random traffic against the model
    rnd_rdy = 1'b1; inp = 1'b0; lm = 2'b00;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      a = $urandom; b = $urandom; m = 2'($urandom_range(0, 3)); l = ($urandom_range(0, 3) == 0);
      eff = inp ? lm : m;
      if (!inp) lm = m;
      inp = !l;
      send({a, b}, l, m, {xf(a, eff), xf(b, eff)}, e);
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    drain();
    if (!inp) begin end else send({2{32'h0}}, 1, 2'b00, {2{32'h0}}, e);
    drain();

    // reset with two beats buffered mid-packet
    M_AXIS_TREADY = 1'b0;
    send({2{32'h12345678}}, 0, 2'b01, {2{32'h1E6A2C48}}, e);
    send({2{32'h12345678}}, 0, 2'b01, {2{32'h1E6A2C48}}, e);
    aresetn = 1'b0; #1;
    exp_q.delete();
    chk("mid_rst_tvalid", M_AXIS_TVALID, 0);
    chk("mid_rst_pkt_active", PKT_ACTIVE, 0);
    chk("mid_rst_active_mode", ACTIVE_MODE, 0);
    chk("mid_rst_tready", S_AXIS_TREADY, 0);
    @(posedge clk); #1; aresetn = 1'b1;
    @(posedge clk); #1;
    M_AXIS_TREADY = 1'b1;
    send({2{32'h12345678}}, 1, 2'b11, {2{32'h482C6A1E}}, e);
    chk("post_rst_mode", ACTIVE_MODE, 3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
